dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences every load/store issued by the MEM stage onto the single-ported data memory.
//  Decodes the 3-bit BEOp and the address low bits into byte enables and store-lane alignment.
//  Runs the request/ack handshake with a variable-latency memory and stalls the pipeline meanwhile.
//  Extracts and extends load data, and flags misaligned accesses and bus timeouts as exceptions.
// PARAMETERS
//  TIMEOUT   16   cycles in REQ without mem_ack before a bus error; 0 = never time out
//  TO_W      5    width of the timeout counter; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req_valid  in   1   MEM stage holds a load/store; held stable while stall=1
//  req_op     in   3   BEOp: 0 SW, 1 SH, 2 SB, 3 LW, 4 LHU, 5 LH, 6 LBU, 7 LB
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-aligned (byte/half in low bits)
//  stall      out  1   freeze pipeline at and before MEM
//  resp_valid out  1   1-cycle pulse: access completed
//  ld_data    out  32  aligned, extended load result; valid with resp_valid
//  exc_valid  out  1   1-cycle pulse: access aborted
//  exc_code   out  2   1 = AdEL (load misaligned), 2 = AdES (store misaligned), 3 = bus timeout
//  mem_req    out  1   memory request, held until mem_ack
//  mem_we     out  1   1 = write
//  mem_addr   out  30  word address, equal to req_addr[31:2]
//  mem_be     out  4   byte enables; bit i selects byte i, i.e. bits [8i+7:8i]
//  mem_wdata  out  32  store data replicated into lanes (SB: {4{b}}, SH: {2{h}})
//  mem_ack    in   1   memory done; rdata valid in the same cycle
//  mem_rdata  in   32  read word
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; timeout counter 0. Reset wins over every other event.
//  FSM states: IDLE, REQ, DONE, ERR.
//  - IDLE, req_valid=0: stay in IDLE.
//  - IDLE, req_valid=1, misaligned: go to ERR. No mem_req is issued.
//    Misaligned = word op with addr[1:0]!=0, or half op with addr[0]!=0.
//  - IDLE, req_valid=1, aligned: go to REQ. Register mem_addr, mem_be, mem_we and mem_wdata.
//  - REQ: mem_req=1. Address, enables and data stay stable until ack. Counter increments each cycle.
//  - REQ, mem_ack=1: go to DONE. For loads, register ld_data from mem_rdata in the same cycle.
//  - REQ, counter reaches TIMEOUT with no ack: go to ERR with code 3.
//    If ack and timeout fall in the same cycle, ack wins.
//  - DONE: resp_valid=1 for one cycle, then IDLE. Back-to-back requests therefore cost 1 idle cycle.
//  - ERR: exc_valid=1 and exc_code valid for one cycle, then IDLE. mem_req stays 0.
//  stall = req_valid & (state is IDLE or REQ). It is combinational, so it rises in the first request cycle.
//  stall is 0 in DONE and ERR, which lets the pipeline advance exactly once per access.
//  Byte enables:
//  - SW/LW: 1111.
//  - SH/LH/LHU: 0011 when addr[1]=0, 1100 when addr[1]=1.
//  - SB/LB/LBU: one-hot 0001 << addr[1:0].
//  Load extract: shift rdata right by 8*addr[1:0].
//  - LW: pass through.
//  - LH / LB: sign-extend bit 15 / bit 7.
//  - LHU / LBU: zero-extend.
//  ld_data and exc_code hold their last value outside pulse cycles.
//  Async reset asserted during REQ drops mem_req immediately; the in-flight access is abandoned.
//  TIMEOUT=0: the counter is disabled and REQ waits indefinitely.
// TESTING
//  SB addr=0x1003, wdata=0xAB, ack after 2 cycles -> mem_be=1000, mem_wdata=0xABABABAB,
//   mem_addr=0x400, stall high 3 cycles, resp_valid 1 cycle.
//  LH addr=0x2002, rdata=0x8001_1234 -> ld_data=0xFFFF8001; LHU same -> 0x00008001;
//   LBU addr=0x2001 -> 0x00000012.
//  LW addr=0x3001 -> exc_valid with code 1, mem_req never asserts; SH addr=0x3003 -> code 2.
//  TIMEOUT=4, no ack -> mem_req high 4 cycles, then exc code 3; retry with ack at the timeout cycle
//   -> resp_valid, no exception.
//  rst_n low during REQ -> mem_req, stall and all pulses 0 immediately; next request proceeds normally.
//  Random op/address/latency stream checked against a reference model for be, wdata, ld_data and stall count.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: decodes BEOp into byte enables / lane data,
// runs the req/ack handshake with a variable-latency memory, and extracts load data.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] ld_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  typedef enum logic [2:0] {
    OP_SW, OP_SH, OP_SB, OP_LW, OP_LHU, OP_LH, OP_LBU, OP_LB
  } op_t;

  state_t          state;
  op_t             op_in;
  op_t             op_q;
  logic [1:0]      off_q;
  logic [TO_W-1:0] to_cnt;

  logic        is_load;
  logic        misaligned;
  logic [3:0]  be_dec;
  logic [31:0] wdata_dec;
  logic [31:0] shifted;
  logic [31:0] ld_ext;

  assign op_in = op_t'(req_op);

  always_comb begin
    is_load    = (req_op >= 3'd3);
    misaligned = 1'b0;
    be_dec     = 4'b0000;
    wdata_dec  = req_wdata;
    case (op_in)
      OP_SW, OP_LW: begin
        be_dec     = 4'b1111;
        misaligned = (req_addr[1:0] != 2'b00);
      end
      OP_SH, OP_LH, OP_LHU: begin
        be_dec     = req_addr[1] ? 4'b1100 : 4'b0011;
        misaligned = req_addr[0];
        wdata_dec  = {2{req_wdata[15:0]}};
      end
      default: begin
        be_dec    = 4'b0001 << req_addr[1:0];
        wdata_dec = {4{req_wdata[7:0]}};
      end
    endcase
  end

  // Opcode and byte offset are captured at issue so extraction does not depend on the held request.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (op_q)
      OP_LHU:  ld_ext = {16'h0000, shifted[15:0]};
      OP_LH:   ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      OP_LBU:  ld_ext = {24'h000000, shifted[7:0]};
      OP_LB:   ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_comb begin
    stall = rst_n & req_valid & ((state == IDLE) | (state == REQ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_SW;
      off_q      <= '0;
      to_cnt     <= '0;
      resp_valid <= 1'b0;
      ld_data    <= '0;
      exc_valid  <= 1'b0;
      exc_code   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      exc_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q  <= op_in;
            off_q <= req_addr[1:0];
            if (misaligned) begin
              state     <= ERR;
              exc_valid <= 1'b1;
              exc_code  <= is_load ? 2'd1 : 2'd2;
            end else begin
              state     <= REQ;
              to_cnt    <= '0;
              mem_req   <= 1'b1;
              mem_we    <= ~is_load;
              mem_addr  <= req_addr[31:2];
              mem_be    <= be_dec;
              mem_wdata <= is_load ? '0 : wdata_dec;
            end
          end
        end
        REQ: begin
          // Ack is tested first so it wins over a timeout landing in the same cycle.
          if (mem_ack) begin
            state      <= DONE;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            if (!mem_we) ld_data <= ld_ext;
          end else if ((TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1))) begin
            state     <= ERR;
            mem_req   <= 1'b0;
            exc_valid <= 1'b1;
            exc_code  <= 2'd3;
          end else if (TIMEOUT != 0) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed and random checks of dmem_access_ctrl against a behavioural model of
// lane decode, load extraction, handshake timing and exceptions.
module tb_dmem_access_ctrl;

  localparam int unsigned TO = 4;
  localparam logic [2:0] SW = 3'd0, SH = 3'd1, SB = 3'd2, LW = 3'd3;
  localparam logic [2:0] LHU = 3'd4, LH = 3'd5, LBU = 3'd6, LB = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] ld_data;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_access_ctrl #(.TIMEOUT(TO), .TO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .resp_valid(resp_valid), .ld_data(ld_data), .exc_valid(exc_valid),
    .exc_code(exc_code), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_misal(input logic [2:0] op, input logic [31:0] addr);
    if (op == SW || op == LW) return addr[1:0] != 2'b00;
    if (op == SH || op == LH || op == LHU) return addr[0];
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] addr);
    if (op == SW || op == LW) return 4'b1111;
    if (op == SH || op == LH || op == LHU) return addr[1] ? 4'b1100 : 4'b0011;
    case (addr[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
    if (op == SH) return {wd[15:0], wd[15:0]};
    if (op == SB) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    return wd;
  endfunction

  function automatic logic [31:0] model_ld(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr[1:0])
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = addr[1] ? rd[31:16] : rd[15:0];
    case (op)
      LW:      return rd;
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'h0000, h};
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'h000000, b};
      default: return 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ack_at: REQ cycle (1-based) in which mem_ack is raised; 0 = never.
  task automatic run_access(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
    int          stall_cnt = 0;
    int          req_cnt   = 0;
    logic        got_resp  = 1'b0;
    logic        got_exc   = 1'b0;
    logic        done      = 1'b0;
    logic [1:0]  code      = 2'd0;
    logic [31:0] ld        = 32'h0;
    logic        misal;
    logic        is_load;
    logic        exp_resp;
    misal     = model_misal(op, addr);
    is_load   = (op >= LW);
    exp_resp  = !misal && (ack_at != 0);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      #1;
      if (stall) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'(addr[31:2]));
        check_eq({tag, "_be"}, 32'(mem_be), 32'(model_be(op, addr)));
        check_eq({tag, "_we"}, 32'(mem_we), 32'(!is_load));
        if (!is_load) check_eq({tag, "_wdata"}, mem_wdata, model_wdata(op, wd));
        if (req_cnt == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
      end
      if (resp_valid) begin
        got_resp = 1'b1;
        ld       = ld_data;
        done     = 1'b1;
      end
      if (exc_valid) begin
        got_exc = 1'b1;
        code    = exc_code;
        done    = 1'b1;
      end
      if (!done) begin
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
      end
    end
    mem_ack = 1'b0;
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_resp"}, 32'(got_resp), 32'(exp_resp));
    check_eq({tag, "_exc"}, 32'(got_exc), 32'(!exp_resp));
    if (!exp_resp)
      check_eq({tag, "_code"}, 32'(code), misal ? (is_load ? 32'd1 : 32'd2) : 32'd3);
    if (exp_resp && is_load) check_eq({tag, "_ld"}, ld, model_ld(op, addr, rd));
    check_eq({tag, "_stalls"}, 32'(stall_cnt),
             misal ? 32'd1 : (ack_at == 0 ? 32'(1 + TO) : 32'(1 + ack_at)));
    check_eq({tag, "_reqcyc"}, 32'(req_cnt),
             misal ? 32'd0 : (ack_at == 0 ? 32'(TO) : 32'(ack_at)));
    step();
    check_eq({tag, "_pulse1"}, 32'(resp_valid | exc_valid), 32'd0);
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1 rst_n  = 1'b0;
    repeat (3) step();
    req_valid = 1'b1;
    #1;
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_be", 32'(mem_be), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_pulses", 32'({resp_valid, exc_valid}), 32'd0);
    check_eq("rst_ld_code", ld_data | 32'(exc_code), 32'd0);
    req_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    run_access("sb", SB, 32'h0000_1003, 32'h0000_00AB, 32'h0, 2);
    check_eq("sb_lit_hold", mem_wdata, 32'hABAB_ABAB);
    run_access("lh", LH, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
    check_eq("lh_lit", ld_data, 32'hFFFF_8001);
    run_access("lhu", LHU, 32'h0000_2002, 32'h0, 32'h8001_1234, 3);
    check_eq("lhu_lit", ld_data, 32'h0000_8001);
    run_access("lbu", LBU, 32'h0000_2001, 32'h0, 32'h8001_1234, 1);
    check_eq("lbu_lit", ld_data, 32'h0000_0012);
    run_access("sw", SW, 32'h0000_2010, 32'hDEAD_BEEF, 32'h0, 1);
    check_eq("ld_hold", ld_data, 32'h0000_0012);
    run_access("lb", LB, 32'h0000_2003, 32'h0, 32'h9A00_0000, 2);
    check_eq("lb_lit", ld_data, 32'hFFFF_FF9A);
    run_access("lw_mis", LW, 32'h0000_3001, 32'h0, 32'h0, 1);
    check_eq("lw_mis_code", 32'(exc_code), 32'd1);
    run_access("sh_mis", SH, 32'h0000_3003, 32'h1234, 32'h0, 1);
    check_eq("sh_mis_code", 32'(exc_code), 32'd2);
    run_access("to", LW, 32'h0000_4000, 32'h0, 32'h0, 0);
    check_eq("to_code", 32'(exc_code), 32'd3);
    run_access("to_ack", LW, 32'h0000_4000, 32'h0, 32'h1357_9BDF, 4);
    check_eq("to_ack_ld", ld_data, 32'h1357_9BDF);

    req_valid = 1'b1;
    req_op    = LW;
    req_addr  = 32'h0000_0400;
    step();
    #1;
    check_eq("rst_req_pre", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req_memreq", 32'(mem_req), 32'd0);
    check_eq("rst_req_stall", 32'(stall), 32'd0);
    check_eq("rst_req_pulses", 32'({resp_valid, exc_valid}), 32'd0);
    check_eq("rst_req_ld", ld_data, 32'd0);
    step();
    req_valid = 1'b0;
    rst_n     = 1'b1;
    step();
    run_access("post_rst", SH, 32'h0000_0502, 32'h0000_CAFE, 32'h0, 2);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] r;
      int          lat;
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      w   = $urandom;
      r   = $urandom;
      lat = int'($urandom_range(0, 4));
      run_access("rnd", op, a, w, r, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
